// File: rtl/control_enable_pipeline.sv
// control_enable_pipeline: run/step sequencer for the MIPS pipeline.
// Drives the common stage enable and the pipeline flush, takes debug-unit
// commands over valid/ready, stops on HALT and counts enabled cycles.
// Optional feature macro: BREAKPOINT_EN (PC breakpoint while running).
module control_enable_pipeline #(
  parameter int CANT_BITS_ADDR     = 11,
  parameter int CANT_BITS_CONTADOR = 32,
  parameter int CANT_CICLOS_FLUSH  = 4
) (
  input  logic                          i_clock,
  input  logic                          i_soft_reset,
  input  logic                          i_cmd_valid,
  input  logic [1:0]                    i_cmd,
  output logic                          o_cmd_ready,
  input  logic                          i_halt_detectado,
  input  logic [CANT_BITS_ADDR-1:0]     i_adder_pc,
`ifdef BREAKPOINT_EN
  input  logic [CANT_BITS_ADDR-1:0]     i_breakpoint_addr,
  input  logic                          i_breakpoint_valid,
`endif
  output logic                          o_enable_pipeline,
  output logic                          o_reset_pipeline,
  output logic [CANT_BITS_CONTADOR-1:0] o_contador_ciclos,
  output logic                          o_step_done,
  output logic                          o_done,
  output logic [2:0]                    o_estado
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_HALT  = 2'b10;
  localparam logic [1:0] CMD_RESET = 2'b11;

  // Flush counter must hold 0..CANT_CICLOS_FLUSH-1.
  localparam int FW = (CANT_CICLOS_FLUSH > 1) ? $clog2(CANT_CICLOS_FLUSH) : 1;

  state_t                        state_q, state_d;
  logic [FW-1:0]                 flush_cnt_q;
  logic [CANT_BITS_CONTADOR-1:0] cnt_q;
  logic                          step_done_q;
  logic                          cmd_acc;
  logic                          flush_last;
  logic                          bp_hit;
  logic                          enable;

  assign enable     = (state_q == S_RUN) || (state_q == S_STEP);
  assign cmd_acc    = i_cmd_valid && o_cmd_ready;
  assign flush_last = (flush_cnt_q == FW'(CANT_CICLOS_FLUSH - 1));

`ifdef BREAKPOINT_EN
  assign bp_hit = i_breakpoint_valid && (i_adder_pc == i_breakpoint_addr);
`else
  // The PC is only consumed by the breakpoint compare.
  logic unused_pc;
  assign unused_pc = ^i_adder_pc;
  assign bp_hit    = 1'b0;
`endif

  // State register; reset clears to IDLE asynchronously.
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Next-state: HALT detection beats breakpoint, which beats commands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          case (i_cmd)
            CMD_RUN:   state_d = S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_RESET: state_d = S_FLUSH;
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt_detectado)                    state_d = S_DONE;
        else if (bp_hit)                         state_d = S_IDLE;
        else if (cmd_acc && i_cmd == CMD_HALT)   state_d = S_IDLE;
        else if (cmd_acc && i_cmd == CMD_RESET)  state_d = S_FLUSH;
      end
      // Single enabled cycle; breakpoints are deliberately not checked.
      S_STEP:  state_d = i_halt_detectado ? S_DONE : S_IDLE;
      S_FLUSH: if (flush_last) state_d = S_IDLE;
      S_DONE:  if (cmd_acc && i_cmd == CMD_RESET) state_d = S_FLUSH;
      default: state_d = S_IDLE;
    endcase
  end

  // Flush length counter, restarts whenever we are outside FLUSH.
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset)            flush_cnt_q <= '0;
    else if (state_q != S_FLUSH) flush_cnt_q <= '0;
    else                         flush_cnt_q <= flush_cnt_q + 1'b1;
  end

  // Enabled-cycle counter: cleared on FLUSH entry, saturates at all-ones.
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset)                                  cnt_q <= '0;
    else if (state_d == S_FLUSH && state_q != S_FLUSH) cnt_q <= '0;
    else if (enable && cnt_q != '1)                    cnt_q <= cnt_q + 1'b1;
  end

  // Step-done pulse in the cycle following STEP.
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) step_done_q <= 1'b0;
    else              step_done_q <= (state_q == S_STEP);
  end

  assign o_enable_pipeline = enable;
  assign o_reset_pipeline  = (state_q == S_FLUSH);
  assign o_done            = (state_q == S_DONE);
  assign o_cmd_ready       = (state_q == S_IDLE) || (state_q == S_RUN) ||
                             (state_q == S_DONE);
  assign o_contador_ciclos = cnt_q;
  assign o_step_done       = step_done_q;
  assign o_estado          = state_q;

endmodule

// File: tb/tb_control_enable_pipeline.sv
// Directed bench for control_enable_pipeline (4-bit counter to reach saturation).
module tb_control_enable_pipeline;

  localparam int AW = 11;
  localparam int CW = 4;

  logic          i_clock, i_soft_reset, i_cmd_valid, i_halt_detectado;
  logic [1:0]    i_cmd;
  logic [AW-1:0] i_adder_pc;
  logic          o_cmd_ready, o_enable_pipeline, o_reset_pipeline;
  logic          o_step_done, o_done;
  logic [CW-1:0] o_contador_ciclos;
  logic [2:0]    o_estado;
`ifdef BREAKPOINT_EN
  logic [AW-1:0] i_breakpoint_addr;
  logic          i_breakpoint_valid;
`endif

  int checks = 0;
  int errors = 0;

  control_enable_pipeline #(
    .CANT_BITS_ADDR(AW), .CANT_BITS_CONTADOR(CW), .CANT_CICLOS_FLUSH(4)
  ) dut (
    .i_clock(i_clock), .i_soft_reset(i_soft_reset),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
    .i_halt_detectado(i_halt_detectado), .i_adder_pc(i_adder_pc),
`ifdef BREAKPOINT_EN
    .i_breakpoint_addr(i_breakpoint_addr), .i_breakpoint_valid(i_breakpoint_valid),
`endif
    .o_enable_pipeline(o_enable_pipeline), .o_reset_pipeline(o_reset_pipeline),
    .o_contador_ciclos(o_contador_ciclos), .o_step_done(o_step_done),
    .o_done(o_done), .o_estado(o_estado)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int st, input int en, input int rp, input int rdy);
    chk({tag, ".estado"}, 32'(o_estado), 32'(st));
    chk({tag, ".enable"}, 32'(o_enable_pipeline), 32'(en));
    chk({tag, ".flush"},  32'(o_reset_pipeline), 32'(rp));
    chk({tag, ".ready"},  32'(o_cmd_ready), 32'(rdy));
  endtask

  task automatic chk_cnt(input string tag, input int v);
    chk({tag, ".cnt"}, 32'(o_contador_ciclos), 32'(v));
  endtask

  task automatic do_reset();
    i_soft_reset = 1'b1;
    tick();
    i_soft_reset = 1'b0;
    tick();
  endtask

  // Directed sequence.
  initial begin
    i_soft_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = 2'b00;
    i_halt_detectado = 1'b0; i_adder_pc = '0;
`ifdef BREAKPOINT_EN
    i_breakpoint_addr = '0; i_breakpoint_valid = 1'b0;
`endif
    repeat (3) tick();
    chk_st("rst", 0, 0, 0, 1);
    chk_cnt("rst", 0);
    chk("rst.done", 32'(o_done), 32'd0);
    chk("rst.sd", 32'(o_step_done), 32'd0);
    i_soft_reset = 1'b0;

    // Idle with no commands
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_st("idle", 0, 0, 0, 1);
      chk_cnt("idle", 0);
    end

    // Three single steps
    for (int k = 1; k <= 3; k++) begin
      send(2'b01);
      chk_st("step", 2, 1, 0, 0);
      chk("step.sd0", 32'(o_step_done), 32'd0);
      tick();
      chk_st("step_end", 0, 0, 0, 1);
      chk("step.sd1", 32'(o_step_done), 32'd1);
      chk_cnt("step_end", k);
      tick();
      chk("step.sd2", 32'(o_step_done), 32'd0);
    end

    // HALT in IDLE is ignored
    send(2'b10);
    chk_st("idle_halt", 0, 0, 0, 1);
    chk_cnt("idle_halt", 3);

    // RUN for 10 enabled cycles, RUN/STEP ignored while running
    do_reset();
    send(2'b00);
    chk_st("run", 1, 1, 0, 1);
    chk_cnt("run0", 0);
    repeat (4) tick();
    chk_cnt("run4", 4);
    send(2'b01);
    chk_st("run_step", 1, 1, 0, 1);
    chk_cnt("run5", 5);
    send(2'b00);
    chk_cnt("run6", 6);
    repeat (3) tick();
    chk_cnt("run9", 9);
    send(2'b10);
    chk_st("run_halt", 0, 0, 0, 1);
    chk_cnt("run_halt", 10);
    tick();
    chk_cnt("run_hold", 10);

    // HALT detection beats HALT command; DONE ignores RUN and halt
    do_reset();
    send(2'b00);
    repeat (2) tick();
    i_halt_detectado = 1'b1;
    send(2'b10);
    i_halt_detectado = 1'b0;
    chk_st("done", 4, 0, 0, 1);
    chk("done.o_done", 32'(o_done), 32'd1);
    chk_cnt("done", 3);
    send(2'b00);
    chk_st("done_run", 4, 0, 0, 1);
    chk_cnt("done_run", 3);
    i_halt_detectado = 1'b1;
    tick();
    i_halt_detectado = 1'b0;
    chk_st("done_hd", 4, 0, 0, 1);

    // RESET_PIPE from DONE: 4 flush cycles, counter cleared
    send(2'b11);
    chk_st("flush0", 3, 0, 1, 0);
    chk_cnt("flush0", 0);
    chk("flush0.done", 32'(o_done), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_st("flush", 3, 0, 1, 0);
    end
    tick();
    chk_st("flush_end", 0, 0, 0, 1);
    chk_cnt("flush_end", 0);

    // Async reset mid-RUN at counter 7
    send(2'b00);
    repeat (7) tick();
    chk_cnt("mid7", 7);
    #2;
    i_soft_reset = 1'b1;
    #1;
    chk_st("async_rst", 0, 0, 0, 1);
    chk_cnt("async_rst", 0);
    i_soft_reset = 1'b0;
    tick();
    send(2'b00);
    chk_st("rerun", 1, 1, 0, 1);
    chk_cnt("rerun0", 0);
    tick();
    chk_cnt("rerun1", 1);

    // Counter saturation at 2^CW-1
    repeat (20) tick();
    chk_cnt("sat", 15);
    send(2'b10);
    chk_st("sat_halt", 0, 0, 0, 1);

    // STEP with HALT detected goes to DONE and still pulses step_done
    send(2'b01);
    i_halt_detectado = 1'b1;
    tick();
    i_halt_detectado = 1'b0;
    chk_st("step_hd", 4, 0, 0, 1);
    chk("step_hd.sd", 32'(o_step_done), 32'd1);
    chk_cnt("step_hd", 15);
    send(2'b11);
    repeat (4) tick();
    chk_st("flush2_end", 0, 0, 0, 1);
    chk_cnt("flush2_end", 0);

`ifdef BREAKPOINT_EN
    // Breakpoint at 0x010 while running from 0x00C
    i_breakpoint_addr = 11'h010; i_breakpoint_valid = 1'b1;
    i_adder_pc = 11'h00C;
    send(2'b00);
    chk_st("bp_run", 1, 1, 0, 1);
    tick(); i_adder_pc = 11'h00D;
    tick(); i_adder_pc = 11'h00E;
    tick(); i_adder_pc = 11'h00F;
    tick(); i_adder_pc = 11'h010;
    chk_st("bp_at", 1, 1, 0, 1);
    tick();
    chk_st("bp_hit", 0, 0, 0, 1);
    chk_cnt("bp_hit", 5);
    send(2'b01);
    chk_st("bp_step", 2, 1, 0, 0);
    tick();
    chk_st("bp_step_end", 0, 0, 0, 1);
    chk("bp_step.sd", 32'(o_step_done), 32'd1);
    chk_cnt("bp_step_end", 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
